// File: rtl/seg7_display_scanner.sv
// seg7_display_scanner: time-multiplexes a 16-bit word onto a 4-digit active-low 7-segment display.
module seg7_display_scanner #(
  parameter int TICK_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] test_value,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   value_q, frame, upper;
  logic [3:0]    nib;
  logic          primed, tick, blank, show;
  // Until primed, decode straight from the input so the first slot already shows the loaded word.
  always_comb begin
    tick  = enable && cnt == LAST;
    frame = primed ? value_q : test_value;
    nib   = frame[{dig, 2'b00} +: 4];
    upper = frame >> {dig, 2'b00};
    blank = BLANK_LZ != 0 && dig != 2'd0 && upper == 16'd0;
    show  = enable && !blank;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt     <= '0;
      dig     <= 2'd0;
      value_q <= 16'd0;
      primed  <= 1'b0;
      an      <= 4'hF;
      seg     <= 7'h7F;
    end else begin
      primed <= 1'b1;
      if (!primed || (tick && dig == 2'd3)) value_q <= test_value;
      if (enable) cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) dig <= dig + 2'd1;
      an  <= show ? ~(4'b0001 << dig) : 4'hF;
      seg <= show ? SEG_LUT[nib] : 7'h7F;
    end
  assign dp = 1'b1;
endmodule

// File: tb/tb_seg7_display_scanner.sv
// tb_seg7_display_scanner: directed checks of scanning, blanking, enable hold, async reset and TICK_DIV=1.
module tb_seg7_display_scanner;
  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [15:0] test_value = 16'd0;
  logic [3:0]  an4, anb, an1;
  logic [6:0]  seg4, segb, seg1;
  logic        dp4, dpb, dp1;
  int vectors = 0, errors = 0;

  seg7_display_scanner #(.TICK_DIV(4), .BLANK_LZ(1)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .test_value(test_value), .an(an4), .seg(seg4), .dp(dp4));
  seg7_display_scanner #(.TICK_DIV(4), .BLANK_LZ(0)) ub (
    .clk(clk), .reset(reset), .enable(enable), .test_value(test_value), .an(anb), .seg(segb), .dp(dpb));
  seg7_display_scanner #(.TICK_DIV(1), .BLANK_LZ(1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .test_value(test_value), .an(an1), .seg(seg1), .dp(dp1));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] v);
    reset = 1'b1;
    test_value = v;
    enable = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({an4, seg4, dp4} !== 12'hFFF) begin errors++; $display("FAIL reset_async u4 got %b_%b_%b want 1111_1111111_1", an4, seg4, dp4); end
    vectors++;
    if ({anb, segb, dpb, an1, seg1, dp1} !== 24'hFFFFFF) begin errors++; $display("FAIL reset_async others got %b %b", {anb, segb, dpb}, {an1, seg1, dp1}); end
    enable = 1'b1;
    test_value = 16'h1A3F;
    step();
    step();
    vectors++;
    if ({an4, seg4, dp4} !== 12'hFFF) begin errors++; $display("FAIL reset_held got %b_%b_%b want 1111_1111111_1", an4, seg4, dp4); end
  endtask

  task automatic test_scan;
    logic [6:0] e [4] = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
    logic [3:0] ea;
    do_reset(16'h1A3F);
    for (int s = 0; s < 5; s++)
      for (int k = 0; k < 4; k++) begin
        step();
        ea = 4'hF;
        ea[s % 4] = 1'b0;
        vectors++;
        if (an4 !== ea || seg4 !== e[s % 4] || dp4 !== 1'b1) begin
          errors++;
          $display("FAIL scan slot%0d cyc%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1", s, k, an4, seg4, dp4, ea, e[s % 4]);
        end
      end
  endtask

  task automatic test_blanking;
    logic [3:0] ea;
    do_reset(16'h0005);
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++) begin
        step();
        ea = 4'hF;
        ea[s] = 1'b0;
        vectors++;
        if (s == 0 ? (an4 !== 4'b1110 || seg4 !== 7'b0010010) : (an4 !== 4'hF || seg4 !== 7'h7F)) begin
          errors++;
          $display("FAIL blank_lz1 slot%0d got an=%b seg=%b", s, an4, seg4);
        end
        vectors++;
        if (anb !== ea || segb !== (s == 0 ? 7'b0010010 : 7'b1000000)) begin
          errors++;
          $display("FAIL blank_lz0 slot%0d got an=%b seg=%b want an=%b", s, anb, segb, ea);
        end
      end
  endtask

  task automatic test_frame_latch;
    logic [6:0] e [8] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001,
                          7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};
    logic [3:0] ea;
    do_reset(16'h1234);
    for (int s = 0; s < 8; s++)
      for (int k = 0; k < 4; k++) begin
        step();
        if (s == 1 && k == 0) test_value = 16'hABCD;
        ea = 4'hF;
        ea[s % 4] = 1'b0;
        vectors++;
        if (an4 !== ea || seg4 !== e[s]) begin
          errors++;
          $display("FAIL frame_latch slot%0d cyc%0d got an=%b seg=%b want an=%b seg=%b", s, k, an4, seg4, ea, e[s]);
        end
      end
  endtask

  task automatic test_enable_hold;
    do_reset(16'h1234);
    for (int i = 0; i < 10; i++) step();
    vectors++;
    if (an4 !== 4'b1011 || seg4 !== 7'b0100100) begin errors++; $display("FAIL pre_disable got an=%b seg=%b want 1011 0100100", an4, seg4); end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (an4 !== 4'hF || seg4 !== 7'h7F) begin errors++; $display("FAIL disabled cyc%0d got an=%b seg=%b want 1111 1111111", i, an4, seg4); end
    end
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (an4 !== 4'b1011 || seg4 !== 7'b0100100) begin errors++; $display("FAIL resume_dig2 cyc%0d got an=%b seg=%b want 1011 0100100", i, an4, seg4); end
    end
    step();
    vectors++;
    if (an4 !== 4'b0111 || seg4 !== 7'b1111001) begin errors++; $display("FAIL resume_dig3 got an=%b seg=%b want 0111 1111001", an4, seg4); end
  endtask

  task automatic test_async_reset_mid;
    do_reset(16'h1234);
    for (int i = 0; i < 13; i++) step();
    vectors++;
    if (an4 !== 4'b0111) begin errors++; $display("FAIL pre_reset_dig3 got an=%b want 0111", an4); end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({an4, seg4, dp4} !== 12'hFFF) begin errors++; $display("FAIL mid_reset got %b_%b_%b want 1111_1111111_1", an4, seg4, dp4); end
    test_value = 16'hABCD;
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (an4 !== 4'b1110 || seg4 !== 7'b0100001) begin errors++; $display("FAIL restart_dig0 cyc%0d got an=%b seg=%b want 1110 0100001", i, an4, seg4); end
    end
    step();
    vectors++;
    if (an4 !== 4'b1101 || seg4 !== 7'b1000110) begin errors++; $display("FAIL restart_dig1 got an=%b seg=%b want 1101 1000110", an4, seg4); end
  endtask

  task automatic test_tick_div1;
    logic [3:0] ea;
    do_reset(16'h8888);
    for (int i = 0; i < 8; i++) begin
      step();
      ea = 4'hF;
      ea[i % 4] = 1'b0;
      vectors++;
      if (an1 !== ea || seg1 !== 7'b0000000) begin errors++; $display("FAIL tick_div1 cyc%0d got an=%b seg=%b want an=%b seg=0000000", i, an1, seg1, ea); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_frame_latch();
    test_enable_hold();
    test_async_reset_mid();
    test_tick_div1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
